// File: rtl/drum_step_sequencer_if.sv
// Control/status bundle between the PS-side controller and drum_step_sequencer.
// The swing field exists only when SEQ_SWING_EN is defined.
interface drum_step_sequencer_if #(
    parameter int unsigned NUM_STEPS  = 16,
    parameter int unsigned NUM_VOICES = 3,
    parameter int unsigned TEMPO_BITS = 16
);
    localparam int unsigned STEP_W = $clog2(NUM_STEPS);

    logic                  pblrc;
    logic                  run;
    logic [TEMPO_BITS-1:0] samples_per_step;
    logic                  wr_en;
    logic [STEP_W-1:0]     wr_step;
    logic [NUM_VOICES-1:0] wr_pattern;
`ifdef SEQ_SWING_EN
    logic [TEMPO_BITS-1:0] swing;
`endif
    logic [NUM_VOICES-1:0] trig;
    logic [STEP_W-1:0]     step_idx;
    logic                  step_strobe;
    logic                  running;

    modport master (
        output pblrc, run, samples_per_step, wr_en, wr_step, wr_pattern,
`ifdef SEQ_SWING_EN
        output swing,
`endif
        input  trig, step_idx, step_strobe, running
    );

    modport slave (
        input  pblrc, run, samples_per_step, wr_en, wr_step, wr_pattern,
`ifdef SEQ_SWING_EN
        input  swing,
`endif
        output trig, step_idx, step_strobe, running
    );
endinterface

// File: rtl/drum_step_sequencer.sv
// Frame-counted drum step sequencer: plays a NUM_STEPS x NUM_VOICES pattern as trigger pulses.
// Define SEQ_SWING_EN to lengthen odd steps by the swing amount.
module drum_step_sequencer #(
    parameter int unsigned NUM_STEPS  = 16,
    parameter int unsigned NUM_VOICES = 3,
    parameter int unsigned TEMPO_BITS = 16,
    parameter int unsigned TRIG_HOLD  = 2
) (
    input logic                  mclk,
    input logic                  rst,
    drum_step_sequencer_if.slave bus
);
    localparam int unsigned STEP_W = $clog2(NUM_STEPS);
    localparam int unsigned HOLD_W = $clog2(TRIG_HOLD + 1);
    localparam int unsigned CNT_W  = TEMPO_BITS + 1;

    typedef enum logic [1:0] {StIdle, StStart, StRun} state_e;

    state_e                state_q;
    logic                  pblrc_q;
    logic [CNT_W-1:0]      frame_cnt_q;
    logic [HOLD_W-1:0]     hold_cnt_q;
    logic [STEP_W-1:0]     step_idx_q;
    logic [NUM_VOICES-1:0] trig_q;
    logic                  step_strobe_q;
    logic [NUM_VOICES-1:0] pattern_q [NUM_STEPS];

    logic                  tick;
    logic [CNT_W-1:0]      period;
    logic [CNT_W-1:0]      period_m1;
    logic                  fire;
    logic [STEP_W-1:0]     fire_step;

    assign tick = pblrc_q & ~bus.pblrc;

    // Period is recomputed every cycle so tempo changes take effect mid-step.
    always_comb begin
        period = {1'b0, bus.samples_per_step};
        if (bus.samples_per_step == '0) begin
            period = CNT_W'(1);
        end
`ifdef SEQ_SWING_EN
        if (step_idx_q[0]) begin
            period = period + {1'b0, bus.swing};
        end
`endif
        period_m1 = period - CNT_W'(1);
    end

    always_comb begin
        fire      = 1'b0;
        fire_step = step_idx_q;
        case (state_q)
            StStart: begin
                fire      = 1'b1;
                fire_step = '0;
            end
            StRun: begin
                if (tick && (frame_cnt_q >= period_m1)) begin
                    fire      = 1'b1;
                    fire_step = step_idx_q + STEP_W'(1);
                end
            end
            default: ;
        endcase
        if (!bus.run) begin
            fire = 1'b0;
        end
    end

    // Fire reads pattern_q before this edge's write lands, so a colliding write plays next lap.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_STEPS); i++) begin
                pattern_q[i] <= '0;
            end
        end else if (bus.wr_en) begin
            pattern_q[bus.wr_step] <= bus.wr_pattern;
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            pblrc_q       <= 1'b0;
            frame_cnt_q   <= '0;
            hold_cnt_q    <= '0;
            step_idx_q    <= '0;
            trig_q        <= '0;
            step_strobe_q <= 1'b0;
        end else begin
            pblrc_q       <= bus.pblrc;
            step_strobe_q <= 1'b0;
            if (!bus.run) begin
                state_q     <= StIdle;
                frame_cnt_q <= '0;
                hold_cnt_q  <= '0;
                step_idx_q  <= '0;
                trig_q      <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        state_q <= StStart;
                    end
                    StStart: begin
                        state_q     <= StRun;
                        frame_cnt_q <= '0;
                    end
                    StRun: begin
                        if (tick) begin
                            frame_cnt_q <= fire ? '0 : frame_cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase

                if (fire) begin
                    trig_q        <= pattern_q[fire_step];
                    step_idx_q    <= fire_step;
                    step_strobe_q <= 1'b1;
                    hold_cnt_q    <= HOLD_W'(TRIG_HOLD);
                end else if ((state_q == StRun) && tick && (hold_cnt_q != '0)) begin
                    hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                    if (hold_cnt_q == HOLD_W'(1)) begin
                        trig_q <= '0;
                    end
                end
            end
        end
    end

    assign bus.trig        = trig_q;
    assign bus.step_idx    = step_idx_q;
    assign bus.step_strobe = step_strobe_q;
    assign bus.running     = (state_q != StIdle);
endmodule
